muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide execution unit, parametrised in operand width, sitting beside the combinational execute stage. It accepts one `INST_TYPE_R_M` / funct7=0000001 operation per start pulse, stalls the pipeline through the control block while it iterates, and returns a single register-file write. Divide is always iterative radix-2. Multiply is either registered single-cycle or iterative, selected at compile time.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_div_core.sv | 53 +++++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode, funct7 and control constants for the RV32M multiply/divide unit.
// The MULDIV_FAST_MUL_EN macro is consumed by muldiv_unit, not by this package.
package muldiv_pkg;

    localparam logic [6:0] INST_FUNCT7_MULDIV = 7'b0000001;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic HOLD_ENABLE   = 1'b1;
    localparam logic HOLD_DISABLE  = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        INST_MUL    = 3'b000,
        INST_MULH   = 3'b001,
        INST_MULHSU = 3'b010,
        INST_MULHU  = 3'b011,
        INST_DIV    = 3'b100,
        INST_DIVU   = 3'b101,
        INST_REM    = 3'b110,
        INST_REMU   = 3'b111
    } muldiv_op_e;

    function automatic logic op1_signed(input muldiv_op_e op);
        return (op == INST_MUL) || (op == INST_MULH) || (op == INST_MULHSU) ||
               (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op2_signed(input muldiv_op_e op);
        return (op == INST_MUL) || (op == INST_MULH) ||
               (op == INST_DIV) || (op == INST_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; one quotient bit per step.
// Sign handling and special cases belong to the parent muldiv_unit.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The dividend is shifted out of the quotient register while quotient bits shift in.
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvsr_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q  <= diff[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q  <= shifted[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: iterative divide, and iterative or
// single-cycle multiply selected by defining MULDIV_FAST_MUL_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    muldiv_op_e        op_q;
    logic [4:0]        rd_addr_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod;

    muldiv_op_e      op;
    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, accept;

    assign op       = muldiv_op_e'(op_i);
    assign s1       = op1_signed(op) & op1_i[XLEN-1];
    assign s2       = op2_signed(op) & op2_i[XLEN-1];
    assign mag1     = s1 ? -op1_i : op1_i;
    assign mag2     = s2 ? -op2_i : op2_i;
    assign div_zero = (op2_i == '0);
    assign div_ovf  = ((op == INST_DIV) || (op == INST_REM)) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    assign accept   = (state == S_IDLE) && start_i && !flush_i;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'($signed({s1, op1_i})) * (2*XLEN)'($signed({s2, op2_i}));
`else
    logic [XLEN-1:0] mul_a;
    logic [XLEN:0]   mul_sum;
    // Multiplier bits are consumed from prod's low half as partial sums fill the high half.
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mul_a} : '0);
`endif

    logic [XLEN-1:0] quot, rem;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && op[2]),
        .step      ((state == S_DIV) && !flush_i),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quot),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= INST_MUL;
            rd_addr_q   <= '0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            special_res <= '0;
            prod        <= '0;
`ifndef MULDIV_FAST_MUL_EN
            mul_a       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q      <= op;
                    rd_addr_q <= rd_addr_i;
                    cnt       <= CNT_W'(XLEN - 1);
                    special_q <= 1'b0;
                    // Remainder follows the dividend sign; everything else the sign xor.
                    neg_q     <= (op == INST_REM) ? s1 : (s1 ^ s2);
                    if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        prod  <= fast_prod;
                        neg_q <= 1'b0;
                        state <= S_DONE;
`else
                        prod  <= {{XLEN{1'b0}}, mag2};
                        mul_a <= mag1;
                        state <= S_MUL;
`endif
                    end else if (div_zero) begin
                        special_q   <= 1'b1;
                        special_res <= op[1] ? op1_i : '1;
                        state       <= S_DONE;
                    end else if (div_ovf) begin
                        special_q   <= 1'b1;
                        special_res <= op[1] ? '0 : op1_i;
                        state       <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state <= S_IDLE;
`else
                        prod <= {mul_sum, prod[XLEN-1:1]};
                        if (cnt == '0) state <= S_DONE;
                        else           cnt   <= cnt - CNT_W'(1);
`endif
                    end
                end
                S_DIV: begin
                    if (flush_i)        state <= S_IDLE;
                    else if (cnt == '0) state <= S_DONE;
                    else                cnt   <= cnt - CNT_W'(1);
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   result;

    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        result = '0;
        if (special_q)
            result = special_res;
        else if (!op_q[2])
            result = (op_q == INST_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op_q[1])
            result = neg_q ? -rem : rem;
        else
            result = neg_q ? -quot : quot;
    end

    assign busy_o    = (state == S_MUL) || (state == S_DIV) || accept;
    assign rd_wen_o  = (state == S_DONE) && !flush_i;
    assign rd_addr_o = (state == S_DONE) ? rd_addr_q : 5'd0;
    assign rd_data_o = (state == S_DONE) ? result : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expected multiply latency follows
// MULDIV_FAST_MUL_EN so the same bench covers both builds.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_o (rd_data_o),
        .rd_wen_o  (rd_wen_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string name);
        tick();
        start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_cycle0: got %b expected 1", name, busy_o);
        end
        tick();
        start_i = 1'b0;
        #1;
    endtask

    // Waits (bounded) for the write strobe starting at cycle cyc_now and checks the result.
    task automatic finish(input string name, input logic [31:0] exp, input logic [4:0] rd,
                          input int lat, input int cyc_now);
        int cyc = cyc_now;
        bit busy_ok = 1'b1;
        bit quiet = 1'b1;
        while (rd_wen_o !== 1'b1 && cyc < 100) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (rd_data_o !== 32'h0 || rd_addr_o !== 5'd0) quiet = 1'b0;
            tick();
            #1;
            cyc++;
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
        end
        checks++;
        if (rd_data_o !== exp) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, rd_data_o, exp);
        end
        checks++;
        if (rd_addr_o !== rd) begin
            errors++;
            $display("FAIL %s addr: got %0d expected %0d", name, rd_addr_o, rd);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_done: got %b expected 0", name, busy_o);
        end
        checks++;
        if (!busy_ok || !quiet) begin
            errors++;
            $display("FAIL %s in_flight: busy_ok=%b quiet=%b expected 1 1", name, busy_ok, quiet);
        end
        tick();
        #1;
        checks++;
        if (rd_wen_o !== 1'b0 || rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s one_cycle: wen=%b data=%h expected 0 0", name, rd_wen_o, rd_data_o);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        launch(op, a, b, rd, name);
        finish(name, exp, rd, lat, 1);
    endtask

    task automatic test_reset();
        int wen_seen = 0;
        rst = 1'b1; flush_i = 1'b0;
        start_i = 1'b1; op_i = INST_DIVU; op1_i = 32'd9; op2_i = 32'd2; rd_addr_i = 5'd1;
        repeat (3) tick();
        #1;
        checks++;
        if (rd_wen_o !== 1'b0 || rd_data_o !== 32'h0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: wen=%b data=%h addr=%0d expected 0 0 0",
                     rd_wen_o, rd_data_o, rd_addr_o);
        end
        tick();
        rst = 1'b0; start_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (rd_wen_o !== 1'b0) wen_seen++;
        end
        checks++;
        if (wen_seen != 0) begin
            errors++;
            $display("FAIL reset_no_write: got %0d writes expected 0", wen_seen);
        end
    endtask

    task automatic test_div_signed();
        run_op("div_100_m7", INST_DIV, 32'd100, 32'hFFFF_FFF9, 5'd5, 32'hFFFF_FFF2, DIV_LAT);
        run_op("rem_100_m7", INST_REM, 32'd100, 32'hFFFF_FFF9, 5'd6, 32'h0000_0002, DIV_LAT);
        run_op("div_m100_7", INST_DIV, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2, DIV_LAT);
        run_op("rem_m100_7", INST_REM, 32'hFFFF_FF9C, 32'd7, 5'd8, 32'hFFFF_FFFE, DIV_LAT);
        run_op("divu_big", INST_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd9, 32'h0FFF_FFFF, DIV_LAT);
        run_op("remu_big", INST_REMU, 32'hFFFF_FFFF, 32'd16, 5'd10, 32'h0000_000F, DIV_LAT);
    endtask

    task automatic test_div_zero();
        run_op("divu_by0", INST_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",  INST_REM,  32'd5, 32'd0, 5'd12, 32'h0000_0005, 1);
        run_op("div_by0",  INST_DIV,  32'hFFFF_FFF0, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_div_overflow();
        run_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1);
    endtask

    task automatic test_mul();
        run_op("mulh_min",  INST_MULH,   32'h8000_0000, 32'h8000_0000, 5'd16, 32'h4000_0000, MUL_LAT);
        run_op("mul_min",   INST_MUL,    32'h8000_0000, 32'h8000_0000, 5'd17, 32'h0000_0000, MUL_LAT);
        run_op("mulhsu_m1", INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_max", INST_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mul_7_m3",  INST_MUL,    32'd7, 32'hFFFF_FFFD, 5'd20, 32'hFFFF_FFEB, MUL_LAT);
    endtask

    task automatic test_flush();
        int wen_seen = 0;
        launch(INST_DIV, 32'd100, 32'd7, 5'd21, "flush_div");
        for (int cyc = 2; cyc <= 10; cyc++) begin
            tick();
            if (cyc == 10) flush_i = 1'b1;
            #1;
            if (rd_wen_o !== 1'b0) wen_seen++;
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || rd_wen_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle11: busy=%b wen=%b expected 0 0", busy_o, rd_wen_o);
        end
        checks++;
        if (wen_seen != 0) begin
            errors++;
            $display("FAIL flush_no_write: got %0d writes expected 0", wen_seen);
        end
        run_op("divu_after_flush", INST_DIVU, 32'd9, 32'd2, 5'd22, 32'd4, DIV_LAT);
    endtask

    task automatic test_start_ignored();
        launch(INST_DIV, 32'd100, 32'd7, 5'd23, "start_ignored");
        for (int cyc = 2; cyc <= 6; cyc++) begin
            tick();
            start_i = (cyc == 5);
            if (cyc == 5) begin
                op_i = INST_DIVU; op1_i = 32'd50; op2_i = 32'd5; rd_addr_i = 5'd9;
            end
            #1;
        end
        finish("start_ignored", 32'd14, 5'd23, DIV_LAT, 6);
    endtask

    task automatic test_rst_mid();
        int wen_seen = 0;
        launch(INST_DIV, 32'd100, 32'd7, 5'd24, "rst_mid");
        for (int cyc = 2; cyc <= 5; cyc++) begin
            tick();
            if (cyc == 5) rst = 1'b1;
            #1;
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rd_wen_o !== 1'b0 || rd_data_o !== 32'h0 || rd_addr_o !== 5'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: wen=%b data=%h addr=%0d busy=%b expected all 0",
                     rd_wen_o, rd_data_o, rd_addr_o, busy_o);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (rd_wen_o !== 1'b0) wen_seen++;
        end
        checks++;
        if (wen_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_no_write: got %0d writes expected 0", wen_seen);
        end
    endtask

    initial begin
        test_reset();
        test_div_signed();
        test_div_zero();
        test_div_overflow();
        test_mul();
        test_flush();
        test_start_ignored();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
